// File: rtl/store_buffer.sv
// Posted-write store buffer between the MEM stage and a byte-addressed data memory.
// Optional feature macro STORE_BUFFER_FWD_EN: serve exact-address loads from the youngest pending store.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [7:0]  req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  req_load_type_i,
  input  logic [1:0]  req_store_type_i,
  input  logic        fence_i,
  output logic        stall_o,
  output logic [31:0] ld_data_o,
  output logic        mem_rd_en_o,
  output logic        mem_wr_en_o,
  output logic [7:0]  mem_addr_o,
  output logic [31:0] mem_wr_data_o,
  output logic [2:0]  mem_load_type_o,
  output logic [1:0]  mem_store_type_o,
  input  logic [31:0] mem_rd_data_i,
  output logic        sb_empty_o,
  output logic        sb_full_o
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  function automatic logic [8:0] ld_width(input logic [2:0] t);
    case (t)
      3'b000, 3'b001: ld_width = 9'd1;
      3'b010, 3'b011: ld_width = 9'd2;
      default:        ld_width = 9'd4;
    endcase
  endfunction

  function automatic logic [8:0] st_width(input logic [1:0] t);
    case (t)
      2'b00:   st_width = 9'd1;
      2'b01:   st_width = 9'd2;
      default: st_width = 9'd4;
    endcase
  endfunction

  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [7:0]      ent_addr_q [DEPTH];
  logic [7:0]      ent_addr_d [DEPTH];
  logic [31:0]     ent_data_q [DEPTH];
  logic [31:0]     ent_data_d [DEPTH];
  logic [1:0]      ent_type_q [DEPTH];
  logic [1:0]      ent_type_d [DEPTH];

  logic            empty, full, conflict;
  logic            stall, load_rd, push, drain;
  logic [31:0]     ld_data;
  logic [PtrW-1:0] slot;
  logic [8:0]      ld_lo, ld_hi, st_lo, st_hi;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));

`ifdef STORE_BUFFER_FWD_EN
  function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] t);
    case (t)
      3'b000:  extend = {{24{d[7]}}, d[7:0]};
      3'b001:  extend = {24'b0, d[7:0]};
      3'b010:  extend = {{16{d[15]}}, d[15:0]};
      3'b011:  extend = {16'b0, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  logic [PtrW-1:0] young_idx;
  logic            fwd_hit;
  logic [31:0]     fwd_data;
`endif

  // Scan entries oldest to youngest; the last hit is the youngest overlapping store.
  always_comb begin
    ld_lo    = {1'b0, req_addr_i};
    ld_hi    = ld_lo + ld_width(req_load_type_i) - 9'd1;
    conflict = 1'b0;
    slot     = head_q;
    st_lo    = '0;
    st_hi    = '0;
`ifdef STORE_BUFFER_FWD_EN
    young_idx = head_q;
`endif
    for (int unsigned a = 0; a < DEPTH; a++) begin
      slot  = head_q + PtrW'(a);
      st_lo = {1'b0, ent_addr_q[slot]};
      st_hi = st_lo + st_width(ent_type_q[slot]) - 9'd1;
      if ((CntW'(a) < count_q) && (st_lo <= ld_hi) && (ld_lo <= st_hi)) begin
        conflict = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        young_idx = slot;
`endif
      end
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  always_comb begin
    fwd_hit  = conflict && (ent_addr_q[young_idx] == req_addr_i) &&
               (st_width(ent_type_q[young_idx]) >= ld_width(req_load_type_i));
    fwd_data = extend(ent_data_q[young_idx], req_load_type_i);
  end
`endif

  always_comb begin
    stall   = 1'b0;
    load_rd = 1'b0;
    push    = 1'b0;
    ld_data = '0;
    if (!rst_n) begin
      stall = 1'b0;
    end else if (fence_i && !empty) begin
      stall = 1'b1;
    end else if (req_valid_i && !req_we_i) begin
      if (!conflict) begin
        load_rd = 1'b1;
        ld_data = mem_rd_data_i;
      end
`ifdef STORE_BUFFER_FWD_EN
      else if (fwd_hit) begin
        ld_data = fwd_data;
      end
`endif
      else begin
        stall = 1'b1;
      end
    end else if (req_valid_i && req_we_i) begin
      if (full) stall = 1'b1;
      else      push  = (req_store_type_i != 2'b11);
    end
    drain = rst_n && !empty && !load_rd;
  end

  always_comb begin
    head_d     = head_q + PtrW'(drain);
    tail_d     = tail_q + PtrW'(push);
    count_d    = count_q + CntW'(push) - CntW'(drain);
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    ent_type_d = ent_type_q;
    if (push) begin
      ent_addr_d[tail_q] = req_addr_i;
      ent_data_d[tail_q] = req_wdata_i;
      ent_type_d[tail_q] = req_store_type_i;
    end
  end

  always_comb begin
    stall_o          = stall;
    ld_data_o        = ld_data;
    mem_rd_en_o      = load_rd;
    mem_wr_en_o      = drain;
    mem_addr_o       = '0;
    mem_wr_data_o    = '0;
    mem_load_type_o  = '0;
    mem_store_type_o = '0;
    if (load_rd) begin
      mem_addr_o      = req_addr_i;
      mem_load_type_o = req_load_type_i;
    end else if (drain) begin
      mem_addr_o       = ent_addr_q[head_q];
      mem_wr_data_o    = ent_data_q[head_q];
      mem_store_type_o = ent_type_q[head_q];
    end
    sb_empty_o = !rst_n || empty;
    sb_full_o  = rst_n && full;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is not reset; count_q alone defines which slots are live.
  always_ff @(posedge clk) begin
    ent_addr_q <= ent_addr_d;
    ent_data_q <= ent_data_d;
    ent_type_q <= ent_type_d;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: queue-based reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_store_buffer;
  localparam int Depth = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_we, fence;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_lt;
  logic [1:0]  req_st;
  logic        stall_o, mem_rd_en_o, mem_wr_en_o, sb_empty_o, sb_full_o;
  logic [31:0] ld_data_o, mem_wr_data_o, mem_rd_data;
  logic [7:0]  mem_addr_o;
  logic [2:0]  mem_load_type_o;
  logic [1:0]  mem_store_type_o;

  int vectors = 0;
  int miscompares = 0;

  store_buffer #(.DEPTH(Depth)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid_i      (req_valid),
    .req_we_i         (req_we),
    .req_addr_i       (req_addr),
    .req_wdata_i      (req_wdata),
    .req_load_type_i  (req_lt),
    .req_store_type_i (req_st),
    .fence_i          (fence),
    .stall_o          (stall_o),
    .ld_data_o        (ld_data_o),
    .mem_rd_en_o      (mem_rd_en_o),
    .mem_wr_en_o      (mem_wr_en_o),
    .mem_addr_o       (mem_addr_o),
    .mem_wr_data_o    (mem_wr_data_o),
    .mem_load_type_o  (mem_load_type_o),
    .mem_store_type_o (mem_store_type_o),
    .mem_rd_data_i    (mem_rd_data),
    .sb_empty_o       (sb_empty_o),
    .sb_full_o        (sb_full_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int ldw(input logic [2:0] t);
    if (t == 3'b000 || t == 3'b001) return 1;
    if (t == 3'b010 || t == 3'b011) return 2;
    return 4;
  endfunction

  function automatic int stw(input logic [1:0] t);
    if (t == 2'b00) return 1;
    if (t == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] raw, input logic [2:0] t);
    case (t)
      3'b000:  return {{24{raw[7]}}, raw[7:0]};
      3'b001:  return {24'b0, raw[7:0]};
      3'b010:  return {{16{raw[15]}}, raw[15:0]};
      3'b011:  return {16'b0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // Data memory seen by the DUT: async read already formatted by load type.
  logic [7:0] dut_mem [256];
  always_comb
    mem_rd_data = ext({dut_mem[mem_addr_o + 8'd3], dut_mem[mem_addr_o + 8'd2],
                       dut_mem[mem_addr_o + 8'd1], dut_mem[mem_addr_o]}, mem_load_type_o);

  initial begin
    for (int i = 0; i < 256; i++) dut_mem[i] = 8'h00;
    forever begin
      @(posedge clk);
      if (mem_wr_en_o)
        for (int b = 0; b < stw(mem_store_type_o); b++)
          dut_mem[mem_addr_o + 8'(b)] = mem_wr_data_o[8*b +: 8];
    end
  end

  // Reference model: pending stores as a queue, architectural memory as a byte array.
  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
    logic [1:0]  t;
  } ent_t;

  ent_t       q[$];
  logic [7:0] ref_mem [256];

  function automatic logic [31:0] ref_read(input logic [7:0] a, input logic [2:0] t);
    return ext({ref_mem[a + 8'd3], ref_mem[a + 8'd2], ref_mem[a + 8'd1], ref_mem[a]}, t);
  endfunction

  initial begin
    bit          e_stall, e_rd, e_push, e_drain, chk_ld;
    logic [31:0] e_ld;
    int          y;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_stall", stall_o, 0);
        chk("rst_rd_en", mem_rd_en_o, 0);
        chk("rst_wr_en", mem_wr_en_o, 0);
        chk("rst_ld_data", ld_data_o, 0);
        chk("rst_empty", sb_empty_o, 1);
        chk("rst_full", sb_full_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        q.delete();
      end else begin
        e_stall = 0; e_rd = 0; e_push = 0; chk_ld = 0; e_ld = '0; y = -1;
        for (int i = 0; i < q.size(); i++)
          if (int'(q[i].a) <= int'(req_addr) + ldw(req_lt) - 1 &&
              int'(req_addr) <= int'(q[i].a) + stw(q[i].t) - 1)
            y = i;
        if (fence && q.size() != 0) begin
          e_stall = 1;
        end else if (req_valid && !req_we) begin
          chk_ld = 1;
          if (y < 0) begin
            e_rd = 1;
            e_ld = ref_read(req_addr, req_lt);
          end
`ifdef STORE_BUFFER_FWD_EN
          else if (q[y].a == req_addr && stw(q[y].t) >= ldw(req_lt)) begin
            e_ld = ext(q[y].d, req_lt);
          end
`endif
          else begin
            e_stall = 1;
          end
        end else if (req_valid && req_we) begin
          if (q.size() == Depth) e_stall = 1;
          else e_push = (req_st != 2'b11);
        end
        e_drain = (q.size() != 0) && !e_rd;

        chk("stall", stall_o, 32'(e_stall));
        chk("rd_en", mem_rd_en_o, 32'(e_rd));
        chk("wr_en", mem_wr_en_o, 32'(e_drain));
        chk("empty", sb_empty_o, 32'(q.size() == 0));
        chk("full", sb_full_o, 32'(q.size() == Depth));
        if (chk_ld) chk("ld_data", ld_data_o, e_ld);
        if (e_rd) begin
          chk("rd_addr", mem_addr_o, req_addr);
          chk("rd_type", mem_load_type_o, req_lt);
        end else if (e_drain) begin
          chk("wr_addr", mem_addr_o, q[0].a);
          chk("wr_data", mem_wr_data_o, q[0].d);
          chk("wr_type", mem_store_type_o, q[0].t);
          for (int b = 0; b < stw(q[0].t); b++) ref_mem[q[0].a + 8'(b)] = q[0].d[8*b +: 8];
          void'(q.pop_front());
        end else begin
          chk("idle_addr", mem_addr_o, 0);
          chk("idle_wdata", mem_wr_data_o, 0);
        end
        if (e_push) q.push_back('{a: req_addr, d: req_wdata, t: req_st});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_lt = '0; req_st = '0;
    fence = 0;
  endtask

  task automatic set_st(input logic [7:0] a, input logic [31:0] d, input logic [1:0] t);
    req_valid = 1; req_we = 1; req_addr = a; req_wdata = d; req_st = t; req_lt = '0;
  endtask

  task automatic set_ld(input logic [7:0] a, input logic [2:0] t);
    req_valid = 1; req_we = 0; req_addr = a; req_wdata = '0; req_lt = t; req_st = '0;
  endtask

  // Hold a request until it is consumed (bounded).
  task automatic issue(input bit we, input logic [7:0] a, input logic [31:0] d,
                       input logic [2:0] lt, input logic [1:0] st);
    bit done = 0;
    if (we) set_st(a, d, st);
    else    set_ld(a, lt);
    for (int n = 0; n < 20 && !done; n++) begin
      #2;
      done = !stall_o;
      tick();
    end
    chk("issue_done", 32'(done), 1);
    idle();
  endtask

  typedef struct {
    bit          we;
    logic [7:0]  a;
    logic [31:0] d;
    logic [2:0]  lt;
    logic [1:0]  st;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl = '{
      '{1, 8'h80, 32'h8001C0DE, 3'd0, 2'b10},
      '{0, 8'h80, 32'h0,        3'd2, 2'b00},
      '{0, 8'h82, 32'h0,        3'd3, 2'b00},
      '{1, 8'h82, 32'h00001234, 3'd0, 2'b01},
      '{0, 8'h80, 32'h0,        3'd4, 2'b00},
      '{1, 8'h83, 32'h00000055, 3'd0, 2'b00},
      '{0, 8'h81, 32'h0,        3'd1, 2'b00},
      '{0, 8'h83, 32'h0,        3'd0, 2'b00}
    };
    rst_n = 0;
    idle();
    tick(); tick();
    #2;
    chk("lit_rst_empty", sb_empty_o, 1);
    chk("lit_rst_stall", stall_o, 0);
    rst_n = 1;
    tick();

    // SW then write next cycle, LW two cycles after the store.
    set_st(8'h10, 32'hDEADBEEF, 2'b10);
    #2 chk("lit_sw_stall", stall_o, 0);
    tick(); idle();
    #2 chk("lit_sw_wr_en", mem_wr_en_o, 1);
    chk("lit_sw_wr_addr", mem_addr_o, 8'h10);
    tick();
    set_ld(8'h10, 3'b100);
    #2 chk("lit_lw_data", ld_data_o, 32'hDEADBEEF);
    chk("lit_lw_stall", stall_o, 0);
    tick(); idle(); tick();

    // Stores interleaved with non-conflicting loads.
    for (int i = 0; i < 5; i++) begin
      set_st(8'h90 + 8'(i), 32'hA0 + 32'(i), 2'b00);
      tick();
      set_ld(8'h10, 3'b100);
      #2 chk("lit_mix_ld", ld_data_o, 32'hDEADBEEF);
      chk("lit_mix_pending", sb_empty_o, 0);
      tick();
    end
    idle(); tick();

    // Partial overlap: SH @0x21 vs LB @0x22 stalls, LB @0x23 does not.
    set_st(8'h20, 32'h7A000000, 2'b10); tick(); idle(); tick();
    set_st(8'h21, 32'h0000BEEF, 2'b01); tick();
    set_ld(8'h22, 3'b000);
    #2 chk("lit_ovl_stall", stall_o, 1);
    chk("lit_ovl_ld0", ld_data_o, 0);
    chk("lit_ovl_rd_en", mem_rd_en_o, 0);
    tick();
    #2 chk("lit_ovl_after", stall_o, 0);
    chk("lit_ovl_data", ld_data_o, 32'hFFFFFFBE);
    tick();
    set_st(8'h21, 32'h0000BEEF, 2'b01); tick();
    set_ld(8'h23, 3'b000);
    #2 chk("lit_nov_stall", stall_o, 0);
    chk("lit_nov_data", ld_data_o, 32'h0000007A);
    tick(); idle(); tick();

    // Exact-address load right behind a store.
    set_st(8'h40, 32'h12345680, 2'b10); tick();
    set_ld(8'h40, 3'b001);
`ifdef STORE_BUFFER_FWD_EN
    #2 chk("lit_fwd_stall", stall_o, 0);
    chk("lit_fwd_rd_en", mem_rd_en_o, 0);
    chk("lit_fwd_data", ld_data_o, 32'h00000080);
    chk("lit_fwd_drain", mem_wr_en_o, 1);
    tick();
`else
    #2 chk("lit_nofwd_stall", stall_o, 1);
    tick();
    #2 chk("lit_nofwd_stall2", stall_o, 0);
    chk("lit_nofwd_data", ld_data_o, 32'h00000080);
    tick();
`endif
    idle(); tick();
    set_st(8'h40, 32'h000000AA, 2'b00); tick();
    set_ld(8'h40, 3'b100);
    #2 chk("lit_narrow_stall", stall_o, 1);
    tick();
    #2 chk("lit_narrow_data", ld_data_o, 32'h123456AA);
    tick(); idle(); tick();

    // Fence with one pending store and a concurrent load.
    set_st(8'h50, 32'h11223344, 2'b10); tick();
    fence = 1; set_ld(8'h50, 3'b100);
    #2 chk("lit_fence_stall", stall_o, 1);
    chk("lit_fence_rd_en", mem_rd_en_o, 0);
    tick();
    #2 chk("lit_fence_done", stall_o, 0);
    chk("lit_fence_empty", sb_empty_o, 1);
    chk("lit_fence_ld", ld_data_o, 32'h11223344);
    tick(); idle(); tick();

    // Reset with a pending store: the store is lost.
    set_st(8'h60, 32'hCAFEF00D, 2'b10); tick();
    rst_n = 0; set_ld(8'h60, 3'b100);
    #2 chk("lit_midrst_wr_en", mem_wr_en_o, 0);
    chk("lit_midrst_rd_en", mem_rd_en_o, 0);
    chk("lit_midrst_ld", ld_data_o, 0);
    chk("lit_midrst_addr", mem_addr_o, 0);
    chk("lit_midrst_empty", sb_empty_o, 1);
    tick();
    rst_n = 1; idle();
    #2 chk("lit_postrst_empty", sb_empty_o, 1);
    chk("lit_postrst_wr_en", mem_wr_en_o, 0);
    tick();
    set_ld(8'h60, 3'b100);
    #2 chk("lit_lost_store", ld_data_o, 0);
    tick();

    // No-op store type is accepted and dropped.
    set_st(8'h70, 32'hFFFFFFFF, 2'b11);
    #2 chk("lit_nop_stall", stall_o, 0);
    tick(); idle();
    #2 chk("lit_nop_empty", sb_empty_o, 1);
    chk("lit_nop_wr_en", mem_wr_en_o, 0);
    tick();

    foreach (tbl[i]) issue(tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].lt, tbl[i].st);
    set_ld(8'h80, 3'b100);
    #2 chk("lit_tbl_word", ld_data_o, 32'h5534C0DE);
    tick(); idle();
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
